deinterleaver: RTL and testbench
================================

# deinterleaver

Receive-side bit deinterleaver for the 802.16 OFDM PHY. It sits between the demodulator (QPSK demapper) and the FEC decoder. It accepts one coded bit per cycle in received (interleaved) order and buffers a full Ncbps-bit block in one half of a ping-pong store. It then releases that block one bit per cycle in original coded order k = 0..Ncbps-1, undoing the two-step transmit permutation.

## Interface
Parameters:
- Ncbps, 192, coded bits per block; must be a multiple of d.
- Ncpc, 2, coded bits per carrier (2 = QPSK); supported values 2, 4, 6.
- s, Ncpc/2, derived, do not override.
- d, 16, permutation column count.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- resetN  in  1  asynchronous, active-low reset.
- valid_demod  in  1  data_in carries a valid received bit.
- data_in  in  1  received bit, index j in arrival order.
- ready_deint  out  1  deinterleaver can accept a bit this cycle.
- ready_dec  in  1  downstream FEC decoder accepts data_out this cycle.
- valid_deint  out  1  data_out is valid.
- data_out  out  1  deinterleaved bit, index k in output order.
- last_out  out  1  high with the bit k = Ncbps-1 of each block.

## Operation
- Storage is two banks of Ncbps bits each, bank0 and bank1. Each bank has a full flag. The storage bits themselves are not reset.
- Write side:
  - State is wr_bank (1 bit) and wr_cnt j (0..Ncbps-1).
  - A bit is accepted when valid_demod && ready_deint. It is written to bank[wr_bank] at address k(j). Then j increments.
  - At j = Ncbps-1 the accept does three things: j wraps to 0, full[wr_bank] is set, and wr_bank toggles.
- Address mapping (inverse of the transmit permutation):
  - m = s*floor(j/s) + ((j + floor(d*j/Ncbps)) mod s)
  - k = d*m - (Ncbps-1)*floor(d*m/Ncbps)
  - For s = 1 this reduces to m = j and k = d*(j mod Ncbps/d) + floor(j/(Ncbps/d)).
  - The mapping must be computed with counters or registered arithmetic, with no combinational dividers on the write path.
  - Example for Ncbps = 192, d = 16, s = 1: j=1 -> k=16; j=12 -> k=1; j=191 -> k=191.
- Read side:
  - State is rd_bank (1 bit) and rd_cnt k (0..Ncbps-1).
  - valid_deint = full[rd_bank].
  - data_out = bank[rd_bank][rd_cnt] when valid_deint, else 0.
  - last_out = valid_deint && rd_cnt == Ncbps-1.
  - A bit is consumed when valid_deint && ready_dec, and rd_cnt increments.
  - On consuming k = Ncbps-1: rd_cnt wraps to 0, full[rd_bank] is cleared, and rd_bank toggles.
- ready_deint = !full[wr_bank].
- Simultaneous events:
  - A block completing on the write side and a block draining on the read side in the same cycle are always on different banks. Both updates take effect.
  - valid_demod arriving while ready_deint = 0 is ignored. No bit is written and j does not advance.
  - ready_dec has no effect while valid_deint = 0.
  - data_out and last_out must stay stable while valid_deint && !ready_dec.

## Timing
- Reset values (asynchronous):
  - wr_bank = 0, rd_bank = 0, wr_cnt = 0, rd_cnt = 0, full = 2'b00.
  - Hence ready_deint = 1, valid_deint = 0, data_out = 0, last_out = 0.
- Reset mid-block discards both banks and any partial block. The first bit accepted after release of resetN is treated as j = 0.
- Latency: if the last bit (j = Ncbps-1) is accepted at edge N, valid_deint is high in the cycle following edge N and data_out is then k = 0.
- Throughput: with continuous valid_demod and ready_dec = 1, both sides sustain 1 bit/clk with no bubbles, in steady state and across block boundaries.
- Backpressure: with ready_dec = 0, exactly 2*Ncbps bits are accepted. ready_deint goes low in the cycle after the 2*Ncbps-th accept.
- Once a bank drains, ready_deint rises in the cycle after the last-bit consume.

## Test plan
- Single-1 mapping, default parameters. One block with a 1 at j=1 and 0 elsewhere -> output has a 1 only at k=16. Repeat with j=12 -> k=1, and j=191 -> k=191.
- Round trip: random 192-bit block passed through the transmit interleaver model, then fed serially -> output bits equal the original block in order k = 0..191. last_out is high only on the 192nd output bit.
- Streaming: three back-to-back blocks with ready_dec = 1 -> first valid_deint one cycle after the 192nd accept. Then 576 contiguous valid outputs with no gaps and ready_deint never low.
- Full backpressure: ready_dec = 0 while 3 blocks are offered -> 384 accepts, then ready_deint = 0. Releasing ready_dec drains blocks 1 and 2 in order. The third block is then accepted and correct.
- Random stalls: random valid_demod and ready_dec duty (about 50%) over 20 blocks -> scoreboard matches and data_out is stable during stalls.
- Reset mid-operation: assert resetN low after 100 bits of block 2, with block 1 still pending -> all outputs at reset values immediately. A new block after release is deinterleaved correctly from j = 0.

Source files
------------

// File: rtl/deinterleaver.sv
// 802.16 OFDM receive bit deinterleaver: ping-pong block store written at the
// inverse-permutation address and read back sequentially in coded order.
module deinterleaver #(
    parameter int Ncbps = 192,
    parameter int Ncpc  = 2,
    parameter int s     = Ncpc / 2,
    parameter int d     = 16
) (
    input  logic clk,
    input  logic resetN,
    input  logic valid_demod,
    input  logic data_in,
    output logic ready_deint,
    input  logic ready_dec,
    output logic valid_deint,
    output logic data_out,
    output logic last_out
);
    localparam int ROWS = Ncbps / d;
    localparam int AW   = $clog2(Ncbps);

    logic [1:0][Ncbps-1:0] mem;
    logic [1:0]            full;
    logic                  wr_bank, rd_bank;
    logic [AW-1:0]         wr_cnt, rd_cnt;

    // j is tracked as base = s*floor(j/s) split into (row, col) over ROWS rows,
    // plus j mod s and floor(j/ROWS) mod s, so k needs only constant multiplies.
    logic [AW-1:0] base_row, base_q, j_row;
    logic [1:0]    j_s, q_mod;
    logic [2:0]    r_sum, r;
    logic [AW-1:0] row_m, wr_addr;

    logic wr_acc, wr_last, rd_acc, rd_last;

    assign ready_deint = !full[wr_bank];
    assign valid_deint = full[rd_bank];
    assign data_out    = valid_deint & mem[rd_bank][rd_cnt];
    assign last_out    = valid_deint && (rd_cnt == AW'(Ncbps - 1));

    assign wr_acc  = valid_demod && ready_deint;
    assign wr_last = wr_acc && (wr_cnt == AW'(Ncbps - 1));
    assign rd_acc  = valid_deint && ready_dec;
    assign rd_last = rd_acc && (rd_cnt == AW'(Ncbps - 1));

    always_comb begin
        r_sum = {1'b0, j_s} + {1'b0, q_mod};
        r     = (r_sum >= 3'(s)) ? r_sum - 3'(s) : r_sum;
        row_m = base_row + AW'(r);
        // m = base + r may step past the last row into the next column
        if (row_m >= AW'(ROWS))
            wr_addr = AW'(d) * (row_m - AW'(ROWS)) + base_q + AW'(1);
        else
            wr_addr = AW'(d) * row_m + base_q;
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_bank][wr_addr] <= data_in;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            full     <= 2'b00;
            base_row <= '0;
            base_q   <= '0;
            j_row    <= '0;
            j_s      <= '0;
            q_mod    <= '0;
        end else begin
            if (wr_last) begin
                wr_cnt   <= '0;
                base_row <= '0;
                base_q   <= '0;
                j_row    <= '0;
                j_s      <= '0;
                q_mod    <= '0;
                wr_bank  <= ~wr_bank;
            end else if (wr_acc) begin
                wr_cnt <= wr_cnt + AW'(1);
                if (j_row == AW'(ROWS - 1)) begin
                    j_row <= '0;
                    q_mod <= (q_mod == 2'(s - 1)) ? 2'd0 : q_mod + 2'd1;
                end else begin
                    j_row <= j_row + AW'(1);
                end
                if (j_s == 2'(s - 1)) begin
                    j_s <= '0;
                    if (base_row + AW'(s) >= AW'(ROWS)) begin
                        base_row <= base_row + AW'(s) - AW'(ROWS);
                        base_q   <= base_q + AW'(1);
                    end else begin
                        base_row <= base_row + AW'(s);
                    end
                end else begin
                    j_s <= j_s + 2'd1;
                end
            end

            if (rd_last) begin
                rd_cnt  <= '0;
                rd_bank <= ~rd_bank;
            end else if (rd_acc) begin
                rd_cnt <= rd_cnt + AW'(1);
            end

            // fill and drain always target different banks
            if (wr_last) full[wr_bank] <= 1'b1;
            if (rd_last) full[rd_bank] <= 1'b0;
        end
    end
endmodule

// File: tb/tb_deinterleaver.sv
// Randomized scoreboard bench for deinterleaver against a transmit-interleaver model.
module tb_deinterleaver;
    localparam int N    = 192;
    localparam int D    = 16;
    localparam int NCPC = 2;
    localparam int S    = NCPC / 2;

    logic clk = 1'b0, resetN = 1'b0;
    logic valid_demod = 1'b0, data_in = 1'b0, ready_dec = 1'b0;
    logic ready_deint, valid_deint, data_out, last_out;

    deinterleaver #(.Ncbps(N), .Ncpc(NCPC), .d(D)) dut (
        .clk(clk), .resetN(resetN), .valid_demod(valid_demod), .data_in(data_in),
        .ready_deint(ready_deint), .ready_dec(ready_dec), .valid_deint(valid_deint),
        .data_out(data_out), .last_out(last_out)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic bit_v; logic last; } exp_t;
    exp_t exp_q[$];
    logic in_q[$];
    int   checks = 0, errors = 0;
    int   vld_duty = 100, rdy_duty = 100, acc_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Transmit side: coded bit k goes out at position j_k.
    function automatic logic [N-1:0] interleave(input logic [N-1:0] orig);
        logic [N-1:0] rx;
        int mk, jk;
        rx = '0;
        for (int k = 0; k < N; k++) begin
            mk = (N / D) * (k % D) + k / D;
            jk = S * (mk / S) + (mk + N - (D * mk) / N) % S;
            rx[jk] = orig[k];
        end
        return rx;
    endfunction

    function automatic logic [N-1:0] rand_block();
        logic [N-1:0] b;
        for (int k = 0; k < N; k++) b[k] = 1'($urandom_range(1));
        return b;
    endfunction

    task automatic push_block(input logic [N-1:0] rx, input logic [N-1:0] ex);
        for (int j = 0; j < N; j++) in_q.push_back(rx[j]);
        for (int k = 0; k < N; k++) exp_q.push_back('{bit_v: ex[k], last: (k == N - 1)});
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(name, int'(c < budget), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk1({tag, "_ready_deint"}, ready_deint, 1'b1);
        chk1({tag, "_valid_deint"}, valid_deint, 1'b0);
        chk1({tag, "_data_out"}, data_out, 1'b0);
        chk1({tag, "_last_out"}, last_out, 1'b0);
    endtask

    // Driver: sole owner of the DUT inputs.
    initial forever begin
        @(posedge clk);
        #1;
        if (in_q.size() > 0 && $urandom_range(99) < vld_duty) begin
            valid_demod = 1'b1;
            data_in     = in_q[0];
        end else begin
            valid_demod = 1'b0;
            data_in     = 1'b0;
        end
        ready_dec = ($urandom_range(99) < rdy_duty);
        @(negedge clk);
        if (resetN && valid_demod && ready_deint && in_q.size() > 0) begin
            void'(in_q.pop_front());
            acc_total++;
        end
    end

    // Monitor: compares every presented output against the scoreboard head.
    initial begin
        logic pstall = 1'b0, pd = 1'b0, pl = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!resetN) begin
                pstall = 1'b0;
            end else begin
                if (pstall) begin
                    chk1("stall_valid", valid_deint, 1'b1);
                    chk1("stall_data", data_out, pd);
                    chk1("stall_last", last_out, pl);
                end
                if (valid_deint) begin
                    if (exp_q.size() == 0) begin
                        chk1("unexpected_output", valid_deint, 1'b0);
                    end else begin
                        e = exp_q[0];
                        chk1("data_out", data_out, e.bit_v);
                        chk1("last_out", last_out, e.last);
                        if (ready_dec) void'(exp_q.pop_front());
                    end
                end else begin
                    chk1("idle_data", data_out, 1'b0);
                    chk1("idle_last", last_out, 1'b0);
                end
                pstall = valid_deint && !ready_dec;
                pd     = data_out;
                pl     = last_out;
            end
        end
    end

    initial begin
        logic [N-1:0] rx, ex;
        int js[3] = '{1, 12, 191};
        int ks[3] = '{16, 1, 191};
        int acc, outs, gaps, lows, t192, tfirst, t384, base;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("reset");
        resetN = 1'b1;

        // single-1 mapping
        for (int i = 0; i < 3; i++) begin
            rx = '0; rx[js[i]] = 1'b1;
            ex = '0; ex[ks[i]] = 1'b1;
            push_block(rx, ex);
            wait_idle("single_drain", 2000);
        end

        // round trip
        repeat (2) begin
            ex = rand_block();
            push_block(interleave(ex), ex);
            wait_idle("roundtrip_drain", 2000);
        end

        // streaming, no stalls
        repeat (3) begin
            ex = rand_block();
            push_block(interleave(ex), ex);
        end
        acc = 0; outs = 0; gaps = 0; lows = 0; t192 = -1; tfirst = -1;
        for (int c = 0; c < 3000 && outs < 3 * N; c++) begin
            @(negedge clk);
            if (acc < 3 * N && !ready_deint) lows++;
            if (valid_deint && tfirst < 0) tfirst = c;
            if (tfirst >= 0 && !valid_deint) gaps++;
            if (valid_deint && ready_dec) outs++;
            if (valid_demod && ready_deint) begin
                acc++;
                if (acc == N) t192 = c;
            end
        end
        chk("stream_latency", tfirst, t192 + 1);
        chk("stream_gaps", gaps, 0);
        chk("stream_ready_low", lows, 0);
        chk("stream_outputs", outs, 3 * N);
        chk("stream_accepts", acc, 3 * N);
        wait_idle("stream_drain", 2000);

        // full backpressure
        rdy_duty = 0;
        repeat (3) begin
            ex = rand_block();
            push_block(interleave(ex), ex);
        end
        acc = 0; t384 = -1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (t384 >= 0 && c == t384 + 1) chk1("bp_ready_low_next", ready_deint, 1'b0);
            if (valid_demod && ready_deint) begin
                acc++;
                if (acc == 2 * N) t384 = c;
            end
        end
        chk("bp_accepts", acc, 2 * N);
        chk1("bp_ready_held_low", ready_deint, 1'b0);
        rdy_duty = 100;
        wait_idle("bp_drain", 3000);

        // random stalls on both sides
        vld_duty = 50; rdy_duty = 50;
        repeat (20) begin
            ex = rand_block();
            push_block(interleave(ex), ex);
        end
        wait_idle("stall_drain", 40000);

        // reset mid-operation: block 1 pending, 100 bits into block 2
        vld_duty = 100; rdy_duty = 0;
        repeat (2) begin
            ex = rand_block();
            push_block(interleave(ex), ex);
        end
        base = acc_total;
        for (int c = 0; c < 1000 && acc_total < base + N + 100; c++) @(posedge clk);
        chk("rst_accepts_before", acc_total - base, N + 100);
        #2;
        resetN = 1'b0;
        in_q.delete();
        exp_q.delete();
        #1;
        chk_reset_outs("rst_mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetN   = 1'b1;
        rdy_duty = 100;
        ex = rand_block();
        push_block(interleave(ex), ex);
        wait_idle("rst_after_drain", 2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
